control_unit_fsm: RTL

- Hardwired Moore control sequencer for the 32-bit datapath.
- Drives every datapath strobe (register-out, register-in, memory, ALU op, CON) so that fetch and execute run from IR with no testbench stepping.
- Sits beside the datapath: consumes the IR opcode and the BranchMet condition flag, produces all control inputs.

---
 rtl/control_unit_fsm.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit_fsm.sv
// Hardwired Moore control sequencer for the 32-bit datapath. Every strobe is a
// pure decode of the registered step plus the IR opcode and BranchMet, so
// fetch and execute run straight from IR with no external stepping.
module control_unit_fsm #(
  parameter int unsigned    OPW    = 5,
  parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [31:0]    IR,
  input  logic           BranchMet,
  input  logic           Stop,
  output logic [OPW-1:0] ALUop,
  output logic           PCout,
  output logic           Zhiout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           HIout,
  output logic           LOout,
  output logic           InPortout,
  output logic           Cout,
  output logic           BAout,
  output logic           Rout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           MARin,
  output logic           MDRin,
  output logic           PCin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           HIin,
  output logic           LOin,
  output logic           OutPortin,
  output logic           CONin,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           Run
);

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  // Instruction families that share one control sequence.
  typedef enum logic [3:0] {
    ClsNop, ClsAlu, ClsImm, ClsNeg, ClsMul, ClsLd, ClsLdi, ClsSt,
    ClsBr, ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsHalt
  } cls_e;

  state_e         state_q, state_d;
  state_e         last_st, done_st;
  cls_e           cls;
  logic [OPW-1:0] op;
  logic           unused_ir;

  assign op        = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];

  // Classify the opcode; anything unlisted behaves as nop.
  always_comb begin
    cls = ClsNop;
    if (op >= OPW'(5'b00011) && op <= OPW'(5'b01010))      cls = ClsAlu;
    else if (op >= OPW'(5'b01011) && op <= OPW'(5'b01101)) cls = ClsImm;
    else if (op == OPW'(5'b01110) || op == OPW'(5'b01111)) cls = ClsMul;
    else if (op == OPW'(5'b10000) || op == OPW'(5'b10001)) cls = ClsNeg;
    else if (op == OPW'(5'b00000)) cls = ClsLd;
    else if (op == OPW'(5'b00001)) cls = ClsLdi;
    else if (op == OPW'(5'b00010)) cls = ClsSt;
    else if (op == OPW'(5'b10010)) cls = ClsBr;
    else if (op == OPW'(5'b10011)) cls = ClsJr;
    else if (op == OPW'(5'b10101)) cls = ClsIn;
    else if (op == OPW'(5'b10110)) cls = ClsOut;
    else if (op == OPW'(5'b10111)) cls = ClsMfhi;
    else if (op == OPW'(5'b11000)) cls = ClsMflo;
    else if (op == OPW'(5'b11010)) cls = ClsHalt;
  end

  // Final execute step of each family and where the sequencer goes after it.
  always_comb begin
    last_st = StT3;
    case (cls)
      ClsNeg:                 last_st = StT4;
      ClsAlu, ClsImm, ClsLdi: last_st = StT5;
      ClsMul, ClsBr:          last_st = StT6;
      ClsLd, ClsSt:           last_st = StT7;
      default:                last_st = StT3;
    endcase
    done_st = (cls == ClsHalt || Stop) ? StHalt : StT0;
  end

  // Next-state sequencing: fetch T0-T2, then execute until the family's last step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:   state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3:    state_d = (last_st == StT3) ? done_st : StT4;
      StT4:    state_d = (last_st == StT4) ? done_st : StT5;
      StT5:    state_d = (last_st == StT5) ? done_st : StT6;
      StT6:    state_d = (last_st == StT6) ? done_st : StT7;
      StT7:    state_d = done_st;
      StHalt:  state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge Clock) begin
    if (!Clear) state_q <= StRst;
    else        state_q <= state_d;
  end

  // Moore output decode; everything idles low with the ALU parked on add.
  always_comb begin
    ALUop     = ADD_OP;
    PCout     = 1'b0;
    Zhiout    = 1'b0;
    Zlowout   = 1'b0;
    MDRout    = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    InPortout = 1'b0;
    Cout      = 1'b0;
    BAout     = 1'b0;
    Rout      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    PCin      = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    OutPortin = 1'b0;
    CONin     = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    Run       = 1'b0;
    unique case (state_q)
      StRst, StHalt: ;
      StT0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      StT1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      StT2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      StT3: begin
        Run = 1'b1;
        case (cls)
          ClsAlu, ClsImm:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsNeg:              begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = op; end
          ClsMul:              begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsLd, ClsLdi, ClsSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          ClsBr:               begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          ClsJr:               begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          ClsIn:               begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsOut:              begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          ClsMfhi:             begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMflo:             begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      StT4: begin
        Run = 1'b1;
        case (cls)
          ClsAlu:               begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = op; end
          ClsImm:               begin Cout = 1'b1; Zin = 1'b1; ALUop = op; end
          ClsNeg:               begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMul:               begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = op; end
          ClsLd, ClsLdi, ClsSt: begin Cout = 1'b1; Zin = 1'b1; end
          ClsBr:                begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      StT5: begin
        Run = 1'b1;
        case (cls)
          ClsAlu, ClsImm, ClsLdi: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMul:                 begin Zlowout = 1'b1; LOin = 1'b1; end
          ClsLd, ClsSt:           begin Zlowout = 1'b1; MARin = 1'b1; end
          ClsBr:                  begin Cout = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      StT6: begin
        Run = 1'b1;
        case (cls)
          ClsMul: begin Zhiout = 1'b1; HIin = 1'b1; end
          ClsLd:  begin Read = 1'b1; MDRin = 1'b1; end
          ClsSt:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // Branch target only lands in PC when the condition held.
          ClsBr:  begin Zlowout = BranchMet; PCin = BranchMet; end
          default: ;
        endcase
      end
      StT7: begin
        Run = 1'b1;
        case (cls)
          ClsLd:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsSt:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
